// File: rtl/sram_rr_arbiter.sv
// Two-requester round-robin front end for a shared scratch SRAM.
// One operation per cycle; read data returns to the issuing requester one cycle later.
module sram_rr_arbiter #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 1024
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,

    output logic                  sram_wen,
    output logic [ADDR_WIDTH-1:0] sram_wadr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    output logic                  sram_ren,
    output logic [ADDR_WIDTH-1:0] sram_radr,
    input  logic [DATA_WIDTH-1:0] sram_rdata
);

    if (DEPTH > (1 << ADDR_WIDTH)) begin : g_depth_chk
        $error("DEPTH does not fit in ADDR_WIDTH");
    end

    logic [1:0]            req_valid;
    logic [1:0]            req_we;
    logic [ADDR_WIDTH-1:0] req_addr  [2];
    logic [DATA_WIDTH-1:0] req_wdata [2];

    assign req_valid    = {req1_valid, req0_valid};
    assign req_we       = {req1_we, req0_we};
    assign req_addr[0]  = req0_addr;
    assign req_addr[1]  = req1_addr;
    assign req_wdata[0] = req0_wdata;
    assign req_wdata[1] = req1_wdata;

    logic       last_grant_reg, last_grant_next;
    logic [1:0] rsp_pend_reg, rsp_pend_next;
    logic [1:0] grant;
    logic       grant_any;
    logic       sel;
    logic       sel_we;

    // Tie goes to whoever was not served last; reset presets last_grant to 1 so 0 wins first.
    always_comb begin
        grant = 2'b00;
        if (!rst) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant_reg ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign grant_any  = |grant;
    assign sel        = grant[1];
    assign sel_we     = req_we[sel];
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    always_comb begin
        sram_wen   = 1'b0;
        sram_wadr  = '0;
        sram_wdata = '0;
        sram_ren   = 1'b0;
        sram_radr  = '0;
        if (grant_any) begin
            if (sel_we) begin
                sram_wen   = 1'b1;
                sram_wadr  = req_addr[sel];
                sram_wdata = req_wdata[sel];
            end else begin
                sram_ren   = 1'b1;
                sram_radr  = req_addr[sel];
            end
        end
    end

    // Tag the next cycle's read return with the requester that issued it.
    for (genvar gi = 0; gi < 2; gi++) begin : g_tag
        assign rsp_pend_next[gi] = grant[gi] & ~req_we[gi];
    end

    assign last_grant_next = grant_any ? sel : last_grant_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_reg <= 1'b1;
            rsp_pend_reg   <= 2'b00;
        end else begin
            last_grant_reg <= last_grant_next;
            rsp_pend_reg   <= rsp_pend_next;
        end
    end

    assign rsp0_valid = rsp_pend_reg[0];
    assign rsp1_valid = rsp_pend_reg[1];
    assign rsp0_rdata = sram_rdata;
    assign rsp1_rdata = sram_rdata;

endmodule
